jk_universal_reg: RTL

Parametrised multi-bit register built on JK flip-flop semantics, the successor to the team's single-bit JK cell. Each bit can be driven independently with per-bit J/K (hold/reset/set/toggle), or the whole register can be parallel-loaded or run as a modulo-N up/down counter with terminal-count and wrap flags. It is used in lab datapaths wherever a bank of JK cells, a loadable register, or a decade/modulo counter is needed, and it cascades through `tc`.

---
 rtl/jk_universal_reg_if.sv | 24 ++
 rtl/jk_universal_reg.sv | 72 +++++++
 2 files changed

// File: rtl/jk_universal_reg_if.sv
// Bus bundle for jk_universal_reg: control/data inputs from the master, register state back from the slave.
interface jk_universal_reg_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
  logic             tc;
  logic             wrap;

  modport master (
    output en, mode, J, K, D,
    input  Q, Qn, tc, wrap
  );

  modport slave (
    input  en, mode, J, K, D,
    output Q, Qn, tc, wrap
  );
endinterface

// File: rtl/jk_universal_reg.sv
// Multi-bit register with per-bit JK, parallel load and modulo-N up/down counting.
// Cascades through tc: tc of one stage drives en of the next.
module jk_universal_reg #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic                CLK,
  input  logic                reset,
  jk_universal_reg_if.slave   bus
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] Q_q, Q_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    Q_d    = Q_q;
    wrap_d = 1'b0;
    if (bus.en) begin
      unique case (bus.mode)
        // Characteristic JK equation, applied to all bits at once.
        MODE_JK:   Q_d = (bus.J & ~Q_q) | (~bus.K & Q_q);
        MODE_LOAD: Q_d = bus.D;
        MODE_UP: begin
          if (Q_q >= LAST) begin
            Q_d    = ZERO;
            wrap_d = 1'b1;
          end else begin
            Q_d = Q_q + ONE;
          end
        end
        MODE_DOWN: begin
          if (Q_q == ZERO) begin
            Q_d    = LAST;
            wrap_d = 1'b1;
          end else if (Q_q > LAST) begin
            // Out-of-range value left by JK/LOAD snaps back without a wrap.
            Q_d = LAST;
          end else begin
            Q_d = Q_q - ONE;
          end
        end
        default: Q_d = Q_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      Q_q    <= ZERO;
      wrap_q <= 1'b0;
    end else begin
      Q_q    <= Q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Q    = Q_q;
  assign bus.Qn   = ~Q_q;
  assign bus.wrap = wrap_q;
  assign bus.tc   = bus.en & (((bus.mode == MODE_UP)   && (Q_q >= LAST)) ||
                              ((bus.mode == MODE_DOWN) && (Q_q == ZERO)));

endmodule
